// File: rtl/xgriscv_dmem_if.sv
// xgriscv_dmem_if: memory-stage request/response bundle between the xgriscv
// pipeline (master) and the data-memory responder (slave).
interface xgriscv_dmem_if #(
  parameter int ADDR_SIZE = 32,
  parameter int XLEN      = 32
);
  logic                 req_i;
  logic                 we_i;
  logic [ADDR_SIZE-1:0] addr_i;
  logic [XLEN-1:0]      wdata_i;
  logic [3:0]           amp_i;
  logic [XLEN-1:0]      rdata_o;
  logic                 ready_o;
  logic                 err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, amp_i,
    input  rdata_o, ready_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, amp_i,
    output rdata_o, ready_o, err_o
  );
endinterface

// File: rtl/xgriscv_dmem_resp.sv
// xgriscv_dmem_resp: word-organised data RAM behind a req/ready handshake with
// WAIT_CYCLES programmable wait states. Stores honour the byte-lane mask and
// are rejected (err_o) when the mask does not match the address alignment.
// Loads return the whole 32-bit word; sub-word extraction is left to the
// datapath. Optional feature macro: XGRISCV_DMEM_RANGE_CHK_EN -- when defined,
// any address bit above the RAM index raises err_o (store dropped, load
// returns 0); otherwise addresses alias modulo the RAM size.
module xgriscv_dmem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           reset,
  xgriscv_dmem_if.slave bus
);

  localparam int XLEN      = 32;
  localparam int ADDR_SIZE = 32;
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Store mask must be one of the naturally aligned byte/half/word patterns.
  function automatic logic storeLegal(input logic [3:0] amp, input logic [1:0] off);
    logic ok;
    case (amp)
      4'b1111: ok = (off == 2'b00);
      4'b0011: ok = (off == 2'b00);
      4'b1100: ok = (off == 2'b10);
      4'b0001: ok = (off == 2'b00);
      4'b0010: ok = (off == 2'b01);
      4'b0100: ok = (off == 2'b10);
      4'b1000: ok = (off == 2'b11);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [XLEN-1:0] mem [0:DEPTH-1];

  state_e                state_r, nextState_s;
  logic [3:0]            waitCnt_r;
  logic                  we_r;
  logic [ADDR_SIZE-1:0]  addr_r;
  logic [XLEN-1:0]       wdata_r;
  logic [3:0]            amp_r;
  logic                  ready_r;
  logic                  err_r;
  logic [XLEN-1:0]       rdata_r;

  logic                  accWe_s;
  logic [ADDR_SIZE-1:0]  accAddr_s;
  logic [XLEN-1:0]       accWdata_s;
  logic [3:0]            accAmp_s;
  logic [DEPTH_LOG2-1:0] wordIdx_s;
  logic                  rangeErr_s;
  logic                  accErr_s;
  logic                  commit_s;
  logic                  memWe_s;

  // Access fields: live bus in IDLE (zero-wait commit), latched copy otherwise.
  always_comb begin
    accWe_s    = we_r;
    accAddr_s  = addr_r;
    accWdata_s = wdata_r;
    accAmp_s   = amp_r;
    if (state_r == IDLE) begin
      accWe_s    = bus.we_i;
      accAddr_s  = bus.addr_i;
      accWdata_s = bus.wdata_i;
      accAmp_s   = bus.amp_i;
    end else begin
      accWe_s    = we_r;
      accAddr_s  = addr_r;
      accWdata_s = wdata_r;
      accAmp_s   = amp_r;
    end
  end

  assign wordIdx_s = accAddr_s[DEPTH_LOG2+1:2];

`ifdef XGRISCV_DMEM_RANGE_CHK_EN
  assign rangeErr_s = |accAddr_s[ADDR_SIZE-1:DEPTH_LOG2+2];
`else
  assign rangeErr_s = 1'b0;
`endif

  // Next-state logic and commit qualification.
  always_comb begin
    nextState_s = state_r;
    accErr_s    = 1'b0;
    memWe_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_i) begin
          if (WAIT_CYCLES == 0) begin
            nextState_s = RESP;
          end else begin
            nextState_s = WAIT;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        if (waitCnt_r == 4'd1) begin
          nextState_s = RESP;
        end else begin
          nextState_s = WAIT;
        end
      end
      RESP:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
    if (accWe_s) begin
      accErr_s = rangeErr_s | ~storeLegal(accAmp_s, accAddr_s[1:0]);
    end else begin
      accErr_s = rangeErr_s;
    end
    // reset gating keeps an access interrupted by reset from reaching the RAM
    memWe_s = commit_s & accWe_s & ~accErr_s & reset;
  end

  assign commit_s = (nextState_s == RESP);

  // FSM state, request capture, wait counter and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      waitCnt_r <= 4'd0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      amp_r     <= 4'd0;
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state_r <= nextState_s;
      ready_r <= commit_s;
      if (state_r == IDLE && bus.req_i) begin
        we_r      <= bus.we_i;
        addr_r    <= bus.addr_i;
        wdata_r   <= bus.wdata_i;
        amp_r     <= bus.amp_i;
        waitCnt_r <= WAIT_INIT;
      end else if (state_r == WAIT) begin
        waitCnt_r <= waitCnt_r - 4'd1;
      end
      if (commit_s) begin
        err_r <= accErr_s;
        if (!accWe_s) begin
          rdata_r <= accErr_s ? '0 : mem[wordIdx_s];
        end
      end
    end
  end

  // RAM write port: only the enabled byte lanes of a legal store change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (memWe_s && accAmp_s[i]) begin
        mem[wordIdx_s][8*i +: 8] <= accWdata_s[8*i +: 8];
      end
    end
  end

  assign bus.ready_o = ready_r;
  assign bus.err_o   = err_r;
  assign bus.rdata_o = rdata_r;

endmodule

// File: tb/tb_xgriscv_dmem_resp.sv
// tb_xgriscv_dmem_resp: directed vectors against two responders,
// WAIT_CYCLES=1 (main function) and WAIT_CYCLES=4 (reset during wait).
module tb_xgriscv_dmem_resp;

  logic clk = 1'b0;
  logic reset1 = 1'b0;
  logic reset4 = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;

  xgriscv_dmem_if bus1 ();
  xgriscv_dmem_if bus4 ();

  xgriscv_dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .bus(bus1)
  );
  xgriscv_dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset4), .bus(bus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One handshake on the selected responder (1 or 4); returns data, error
  // and the number of falling edges from request to ready.
  task automatic access(input int which, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] amp,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic rdy;
    @(negedge clk);
    if (which == 4) begin
      bus4.req_i = 1'b1; bus4.we_i = we; bus4.addr_i = addr; bus4.wdata_i = wdata; bus4.amp_i = amp;
    end else begin
      bus1.req_i = 1'b1; bus1.we_i = we; bus1.addr_i = addr; bus1.wdata_i = wdata; bus1.amp_i = amp;
    end
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy = (which == 4) ? bus4.ready_o : bus1.ready_o;
    end
    if (!rdy) check("ready_timeout", 32'd0, 32'd1);
    rdata = (which == 4) ? bus4.rdata_o : bus1.rdata_o;
    err   = (which == 4) ? bus4.err_o   : bus1.err_o;
    bus1.req_i = 1'b0;
    bus4.req_i = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", 32'((which == 4) ? bus4.ready_o : bus1.ready_o), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        sawReady;

  initial begin
    bus1.req_i = 1'b1; bus1.we_i = 1'b1; bus1.addr_i = 32'h10;
    bus1.wdata_i = 32'hDEADBEEF; bus1.amp_i = 4'b1111;
    bus4.req_i = 1'b0; bus4.we_i = 1'b0; bus4.addr_i = 32'h0;
    bus4.wdata_i = 32'h0; bus4.amp_i = 4'b0000;

    // Reset held with a pending request for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(bus1.ready_o), 32'd0);
      check("rst_err",   32'(bus1.err_o),   32'd0);
      check("rst_rdata", bus1.rdata_o,      32'd0);
    end
    reset1 = 1'b1;
    reset4 = 1'b1;
    lat = 0;
    sawReady = 1'b0;
    while (!sawReady && lat < 20) begin
      @(negedge clk);
      lat++;
      sawReady = bus1.ready_o;
    end
    check("rst_first_lat", 32'(lat), 32'd2);
    check("rst_first_err", 32'(bus1.err_o), 32'd0);
    bus1.req_i = 1'b0;

    // Word store / load.
    access(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    check("word_load_lat",  32'(lat), 32'd2);
    check("word_load_data", rd, 32'hDEADBEEF);
    check("word_load_err",  32'(er), 32'd0);

    // Byte and halfword lanes.
    access(1, 1'b1, 32'h20, 32'h11223344, 4'b1111, rd, er, lat);
    check("lane_init_err", 32'(er), 32'd0);
    access(1, 1'b1, 32'h21, 32'h0000AA00, 4'b0010, rd, er, lat);
    check("byte1_err", 32'(er), 32'd0);
    check("store_keeps_rdata", rd, 32'hDEADBEEF);
    access(1, 1'b1, 32'h22, 32'hBBBB0000, 4'b1100, rd, er, lat);
    check("half_hi_err", 32'(er), 32'd0);
    access(1, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    check("lane_merge", rd, 32'hBBBBAA44);

    // Misaligned half store and an empty mask are rejected.
    access(1, 1'b1, 32'h21, 32'hFFFFFFFF, 4'b0011, rd, er, lat);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_rdata_held", rd, 32'hBBBBAA44);
    access(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    check("mask0_err", 32'(er), 32'd1);
    access(1, 1'b0, 32'h23, 32'h0, 4'b0000, rd, er, lat);
    check("unaligned_load_data", rd, 32'hBBBBAA44);
    check("unaligned_load_err",  32'(er), 32'd0);

    // Top byte lane.
    access(1, 1'b1, 32'h23, 32'h99000000, 4'b1000, rd, er, lat);
    check("byte3_err", 32'(er), 32'd0);
    access(1, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    check("byte3_merge", rd, 32'h99BBAA44);

    // Address above the RAM: 4*1024 + 0x10.
    access(1, 1'b1, 32'h1010, 32'h77, 4'b1111, rd, er, lat);
`ifdef XGRISCV_DMEM_RANGE_CHK_EN
    check("range_store_err", 32'(er), 32'd1);
`else
    check("range_store_err", 32'(er), 32'd0);
`endif
    access(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
`ifdef XGRISCV_DMEM_RANGE_CHK_EN
    check("range_alias_data", rd, 32'hDEADBEEF);
`else
    check("range_alias_data", rd, 32'h77);
`endif
    access(1, 1'b0, 32'h1010, 32'h0, 4'b0000, rd, er, lat);
`ifdef XGRISCV_DMEM_RANGE_CHK_EN
    check("range_load_data", rd, 32'h0);
    check("range_load_err",  32'(er), 32'd1);
`else
    check("range_load_data", rd, 32'h77);
    check("range_load_err",  32'(er), 32'd0);
`endif

    // Reset during the second wait cycle, WAIT_CYCLES=4.
    access(4, 1'b1, 32'h30, 32'h0, 4'b1111, rd, er, lat);
    check("w4_lat", 32'(lat), 32'd5);
    @(negedge clk);
    bus4.req_i = 1'b1; bus4.we_i = 1'b1; bus4.addr_i = 32'h30;
    bus4.wdata_i = 32'h55; bus4.amp_i = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    reset4 = 1'b0;
    bus4.req_i = 1'b0;
    #1;
    check("midrst_ready", 32'(bus4.ready_o), 32'd0);
    check("midrst_err",   32'(bus4.err_o),   32'd0);
    sawReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus4.ready_o) sawReady = 1'b1;
    end
    check("midrst_no_ready", 32'(sawReady), 32'd0);
    reset4 = 1'b1;
    access(4, 1'b0, 32'h30, 32'h0, 4'b0000, rd, er, lat);
    check("midrst_ram_kept", rd, 32'h0);
    check("midrst_load_lat", 32'(lat), 32'd5);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
